// File: rtl/jk_pkg.sv
// Shared definitions for the JK command sequencer: op codes, FSM states and the JK next-state rule.
// latency: n/a (types and a pure function); backpressure: n/a.
package jk_pkg;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_CLR  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_TGL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    function automatic logic jk_next(input logic j, input logic k, input logic q);
        logic nq;
        case ({j, k})
            OP_HOLD: nq = q;
            OP_CLR:  nq = 1'b0;
            OP_SET:  nq = 1'b1;
            default: nq = ~q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Generic synchronous FIFO with occupancy; head word is visible combinationally on pop_data.
// latency: write visible at head one edge after push; backpressure: push ignored when full, pop ignored when empty.
module jk_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Extra wrap bit distinguishes full from empty when the address bits match.
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign level    = wr_ptr - rd_ptr;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Buffers hold/clear/set/toggle commands and replays them as registered j/k with hold gaps; shadows q and flags mismatches.
// latency: accept at edge N drives j/k at edge N+1 when idle; backpressure: cmd_ready low only while the FIFO is full.
module jk_cmd_sequencer
    import jk_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int REPW  = 4,
    parameter int GAP   = 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [REPW-1:0]          cmd_rep,
    output logic                     j,
    output logic                     k,
    input  logic                     q_fb,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err,
    input  logic                     err_clr
);

    localparam int         FW     = 2 + REPW;
    localparam logic [2:0] GAP_LD = 3'((GAP > 0) ? GAP - 1 : 0);

    state_t            state;
    logic [REPW-1:0]   cnt;
    logic [2:0]        gcnt;
    logic              full;
    logic              empty;
    logic              pop;
    logic [FW-1:0]     head;
    logic [1:0]        head_op;
    logic [REPW-1:0]   head_rep;
    logic [REPW-1:0]   load_cnt;
    logic              exp_q;
    logic              chk_arm;
    logic              chk_en;

    jk_cmd_fifo #(.DEPTH(DEPTH), .W(FW)) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (cmd_valid),
        .push_data ({cmd_op, cmd_rep}),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    assign cmd_ready = !full;
    assign head_op   = head[FW-1:REPW];
    assign head_rep  = head[REPW-1:0];
    assign load_cnt  = (head_rep == '0) ? '0 : head_rep - 1'b1;
    assign busy      = (state != ST_IDLE) || (level != '0);

    // A pop is exactly the condition under which the FSM loads a new command.
    always_comb begin
        pop = 1'b0;
        case (state)
            ST_IDLE:  pop = !empty;
            ST_ISSUE: pop = (cnt == '0) && (GAP == 0) && !empty;
            ST_GAP:   pop = (gcnt == '0) && !empty;
            default:  pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
            j     <= 1'b0;
            k     <= 1'b0;
            cnt   <= '0;
            gcnt  <= '0;
        end else if (pop) begin
            state <= ST_ISSUE;
            j     <= head_op[1];
            k     <= head_op[0];
            cnt   <= load_cnt;
        end else begin
            case (state)
                ST_ISSUE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (GAP > 0) begin
                        state <= ST_GAP;
                        gcnt  <= GAP_LD;
                        j     <= 1'b0;
                        k     <= 1'b0;
                    end else begin
                        state <= ST_IDLE;
                        j     <= 1'b0;
                        k     <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (gcnt != '0) begin
                        gcnt <= gcnt - 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    j     <= 1'b0;
                    k     <= 1'b0;
                end
            endcase
        end
    end

    // chk_en waits out the flop's own synchronous reset edge before comparing.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            exp_q   <= 1'b0;
            chk_arm <= 1'b0;
            chk_en  <= 1'b0;
            err     <= 1'b0;
        end else begin
            exp_q   <= jk_next(j, k, exp_q);
            chk_arm <= 1'b1;
            chk_en  <= chk_arm;
            if (err_clr) begin
                err <= 1'b0;
            end else if (chk_en && (q_fb != exp_q)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench: one sequencer with GAP=1 and one with GAP=0, each driving a behavioural JK flop.
module tb_jk_cmd_sequencer;
    import jk_pkg::*;

    logic       clk;
    logic       rstn;
    logic       cmd_valid, cmd_valid0;
    logic [1:0] cmd_op;
    logic [3:0] cmd_rep;
    logic       err_clr;
    logic       force_en, force_val;

    logic       cmd_ready, j, k, busy, err, q_fb;
    logic [2:0] level;
    logic       cmd_ready0, j0, k0, busy0, err0, q_fb0;
    logic [2:0] level0;

    logic       q_flop, q_flop0;

    int vectors;
    int miscompares;

    logic [1:0] exp_jk0 [5];
    logic       exp_q0  [5];

    jk_cmd_sequencer #(.DEPTH(4), .REPW(4), .GAP(1)) u_dut (
        .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rep(cmd_rep), .j(j), .k(k), .q_fb(q_fb),
        .busy(busy), .level(level), .err(err), .err_clr(err_clr)
    );

    jk_cmd_sequencer #(.DEPTH(4), .REPW(4), .GAP(0)) u_dut0 (
        .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
        .cmd_op(cmd_op), .cmd_rep(cmd_rep), .j(j0), .k(k0), .q_fb(q_fb0),
        .busy(busy0), .level(level0), .err(err0), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural JK flops with synchronous reset; q_fb of the first can be overridden.
    always @(posedge clk) begin
        q_flop  <= !rstn ? 1'b0 : jk_next(j, k, q_flop);
        q_flop0 <= !rstn ? 1'b0 : jk_next(j0, k0, q_flop0);
    end
    assign q_fb  = force_en ? force_val : q_flop;
    assign q_fb0 = q_flop0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rstn        = 1'b0;
        cmd_valid   = 1'b0;
        cmd_valid0  = 1'b0;
        cmd_op      = 2'b00;
        cmd_rep     = 4'd0;
        err_clr     = 1'b0;
        force_en    = 1'b0;
        force_val   = 1'b0;
        exp_jk0 = '{2'b11, 2'b11, 2'b11, 2'b01, 2'b00};
        exp_q0  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset and idle
        tick(3);
        chk("rst_jk",    32'({j, k}), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_err",   32'(err), 0);
        chk("rst_busy",  32'(busy), 0);
        rstn = 1'b1;
        chk("rst_ready", 32'(cmd_ready), 1);
        tick(10);
        chk("idle_q",    32'(q_flop), 0);
        chk("idle_err",  32'(err), 0);
        chk("idle_jk",   32'({j, k}), 0);
        chk("idle_rdy0", 32'(cmd_ready0), 1);

        // Single set rep=3, GAP=1
        cmd_valid = 1'b1; cmd_op = OP_SET; cmd_rep = 4'd3;
        tick(1);
        cmd_valid = 1'b0;
        chk("set_lvl_acc", 32'(level), 1);
        chk("set_j_acc",   32'(j), 0);
        chk("set_busy",    32'(busy), 1);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("set_jk_on", 32'({j, k}), 2);
        end
        chk("set_lvl_pop", 32'(level), 0);
        tick(1);
        chk("set_gap_jk",   32'({j, k}), 0);
        chk("set_gap_busy", 32'(busy), 1);
        tick(1);
        chk("set_done_busy", 32'(busy), 0);
        chk("set_q",         32'(q_flop), 1);
        chk("set_err",       32'(err), 0);

        // Toggle rep=4 then clear rep=0, GAP=0
        cmd_valid0 = 1'b1; cmd_op = OP_TGL; cmd_rep = 4'd4;
        tick(1);
        cmd_op = OP_CLR; cmd_rep = 4'd0;
        tick(1);
        cmd_valid0 = 1'b0;
        chk("tgl_jk_first", 32'({j0, k0}), 3);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("tgl_q",  32'(q_flop0), 32'(exp_q0[i]));
            chk("tgl_jk", 32'({j0, k0}), 32'(exp_jk0[i]));
        end
        chk("tgl_busy0",  32'(busy0), 0);
        chk("tgl_level0", 32'(level0), 0);
        chk("tgl_err0",   32'(err0), 0);

        // Full FIFO behind a long set command
        cmd_valid = 1'b1; cmd_op = OP_SET; cmd_rep = 4'd15;
        tick(1);
        cmd_valid = 1'b0;
        tick(1);
        chk("full_long_jk", 32'({j, k}), 2);
        cmd_valid = 1'b1; cmd_op = OP_SET; cmd_rep = 4'd1;
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            chk("full_lvl_fill", 32'(level), 32'(i));
            chk("full_ready",    32'(cmd_ready), 1);
        end
        tick(1);
        chk("full_lvl4",   32'(level), 4);
        chk("full_ready0", 32'(cmd_ready), 0);
        tick(1);
        cmd_valid = 1'b0;
        chk("full_blocked", 32'(level), 4);
        tick(10);
        chk("full_still_busy", 32'(level), 4);
        tick(1);
        chk("full_pop1", 32'(level), 3);
        tick(1);
        chk("full_gap_lvl", 32'(level), 3);
        chk("full_gap_jk",  32'({j, k}), 0);
        chk("full_rdy_l3",  32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        tick(1);
        cmd_valid = 1'b0;
        chk("full_pushpop", 32'(level), 3);
        tick(30);
        chk("drain_busy",  32'(busy), 0);
        chk("drain_level", 32'(level), 0);
        chk("drain_q",     32'(q_flop), 1);
        chk("drain_err",   32'(err), 0);

        // Mismatch and err_clr priority
        force_en = 1'b1; force_val = 1'b0;
        tick(1);
        force_en = 1'b0;
        chk("mm_rise", 32'(err), 1);
        tick(1);
        chk("mm_sticky", 32'(err), 1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("mm_clr", 32'(err), 0);
        tick(1);
        chk("mm_clr_hold", 32'(err), 0);
        force_en = 1'b1; err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("mm_clr_wins", 32'(err), 0);
        tick(1);
        force_en = 1'b0;
        chk("mm_reassert", 32'(err), 1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("mm_final_clr", 32'(err), 0);

        // Reset mid-ISSUE with two queued commands
        cmd_valid = 1'b1; cmd_op = OP_CLR; cmd_rep = 4'd8;
        tick(1);
        cmd_op = OP_SET; cmd_rep = 4'd2;
        tick(2);
        cmd_valid = 1'b0;
        chk("mid_jk",    32'({j, k}), 1);
        chk("mid_level", 32'(level), 2);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_jk",    32'({j, k}), 0);
        chk("arst_level", 32'(level), 0);
        chk("arst_busy",  32'(busy), 0);
        tick(2);
        rstn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            chk("post_rst_jk", 32'({j, k}), 0);
        end
        chk("post_rst_level", 32'(level), 0);
        chk("post_rst_err",   32'(err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
